// File: rtl/core_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared core ALU.
// One ALU operation per RUN cycle: shift-add multiply, restoring divide, XLEN iterations.
module core_muldiv_seq #(
  parameter int                  XLEN     = 32,
  parameter int                  ALU_OP_W = 4,
  parameter logic [ALU_OP_W-1:0] ADD_ALU  = 4'd0,
  parameter logic [ALU_OP_W-1:0] SUB_ALU  = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [XLEN-1:0]     req_a,
  input  logic [XLEN-1:0]     req_b,
  input  logic                kill,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_data,
  output logic                busy,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_src1,
  output logic [XLEN-1:0]     alu_src2,
  input  logic [XLEN-1:0]     alu_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;

  logic            accept, div0, take, carry;
  logic [XLEN-1:0] sh, hi_n, lo_n;

  // Handshake: a request moves on an edge where req_valid & req_ready; a
  // response is consumed on an edge where resp_valid & resp_ready.
  assign req_ready  = (state_q == S_IDLE) & ~kill & ~rst;
  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = resp_data_q;

  assign accept = req_valid & req_ready;
  assign div0   = req_op[1] & (req_b == '0);

  // Divide step: shifted partial remainder; the dropped msb forces a subtract.
  assign sh    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign take  = hi_q[XLEN-1] | (sh >= opnd_q);
  assign carry = (alu_result < hi_q);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    alu_op      = ADD_ALU;
    alu_src1    = '0;
    alu_src2    = '0;
    hi_n        = hi_q;
    lo_n        = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hi_d   = '0;
          lo_d   = req_a;
          opnd_d = req_b;
          op_d   = req_op;
          cnt_d  = CW'(XLEN - 1);
          if (div0) begin
            state_d     = S_DONE;
            resp_data_d = req_op[0] ? req_a : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_q[1]) begin
          alu_op   = SUB_ALU;
          alu_src1 = sh;
          alu_src2 = opnd_q;
          hi_n     = take ? alu_result : sh;
          lo_n     = {lo_q[XLEN-2:0], take};
        end else begin
          alu_op       = ADD_ALU;
          alu_src1     = hi_q;
          alu_src2     = lo_q[0] ? opnd_q : '0;
          {hi_n, lo_n} = {carry, alu_result, lo_q[XLEN-1:1]};
        end
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          resp_data_d = op_q[0] ? hi_n : lo_n;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_core_muldiv_seq.sv
// Randomized and directed bench for core_muldiv_seq against a plain-arithmetic
// reference model, with a combinational ALU model on the shared-ALU ports.
module tb_core_muldiv_seq;

  localparam int         XLEN = 32;
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;

  logic            clk, rst;
  logic            req_valid, req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            kill;
  logic            resp_valid, resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_src1, alu_src2, alu_result;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  core_muldiv_seq #(.XLEN(XLEN), .ALU_OP_W(4), .ADD_ALU(ADD), .SUB_ALU(SUB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result)
  );

  // Shared ALU stand-in.
  assign alu_result = (alu_op == SUB) ? alu_src1 - alu_src2 : alu_src1 + alu_src2;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      2'd0:    return p[XLEN-1:0];
      2'd1:    return p[2*XLEN-1:XLEN];
      2'd2:    return (b == 0) ? {XLEN{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_rvld"},  resp_valid, 0);
    check_eq({tag, "_aluop"}, alu_op, ADD);
    check_eq({tag, "_src"},   alu_src1 | alu_src2, 0);
  endtask

  // Driver: issue one op, wait for the response, optionally stall it, then drain.
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int hold);
    int k, busy_cycles, lat_exp;
    logic alu_bad;
    logic [XLEN-1:0] got;
    resp_ready = (hold == 0);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    #1;
    check_eq("req_ready_idle", req_ready, 1);
    exp_q.push_back(ref_model(op, a, b));
    lat_exp = (op[1] && b == 0) ? 1 : XLEN + 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom_range(0, 3));
    k = 1; busy_cycles = 0; alu_bad = 1'b0;
    while (!resp_valid && k < 100) begin
      busy_cycles += int'(busy);
      if (alu_op != (op[1] ? SUB : ADD)) alu_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check_eq("latency", k, lat_exp);
    check_eq("busy_cycles", busy_cycles, lat_exp - 1);
    check_eq("alu_op_run", alu_bad, 0);
    check_eq("alu_idle_done", {alu_op, alu_src1 | alu_src2} == {ADD, {XLEN{1'b0}}}, 1);
    got = resp_data;
    check_eq("data", got, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_data", resp_data, got);
      check_eq("hold_valid", resp_valid, 1);
      check_eq("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("drained_valid", resp_valid, 0);
    check_eq("drained_busy", busy, 0);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int seen;
    logic [1:0] op;
    logic [XLEN-1:0] a, b;
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_idle("reset");
    check_eq("reset_req_ready", req_ready, 0);
    check_eq("reset_data", resp_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 32'd7, 32'd6, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'd100, 32'd7, 0);
    run_op(2'd3, 32'd100, 32'd7, 0);
    run_op(2'd2, 32'h8000_0000, 32'd1, 0);
    run_op(2'd2, 32'd5, 32'd0, 0);
    run_op(2'd3, 32'd5, 32'd0, 0);
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    run_op(2'd3, 32'd5, 32'd0, 3);

    // Kill at RUN iteration 10: the result must never appear.
    start_op(2'd0, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    #1;
    check_eq("kill_busy_before", busy, 1);
    check_eq("kill_req_ready", req_ready, 0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check_outputs_idle("kill");
    check_eq("kill_req_ready_after", req_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check_eq("kill_no_resp", seen, 0);

    // Kill in IDLE blocks an accept in the same cycle.
    req_valid = 1'b1; kill = 1'b1;
    #1;
    check_eq("kill_idle_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check_eq("kill_idle_busy", busy, 0);

    // Kill in DONE with resp_ready low drops the pending result.
    resp_ready = 1'b0;
    start_op(2'd2, 32'd9, 32'd0);
    check_eq("kill_done_valid", resp_valid, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill_done_dropped", resp_valid, 0);
    resp_ready = 1'b1;

    // Reset mid-RUN, then a normal multiply.
    start_op(2'd2, 32'hDEAD_BEEF, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_idle("rst_mid");
    check_eq("rst_mid_req_ready", req_ready, 0);
    check_eq("rst_mid_data", resp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd0, 32'd7, 32'd6, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = a;
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
